// File: rtl/mdu_ctrl_if.sv
// Handshake and result bus between the EX stage and the multiply/divide unit.
// The master is the EX stage. The slave is the MDU.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        ready;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, src_a, src_b, flush,
                  input  ready, busy, hi, lo);
  modport slave  (input  start, op, src_a, src_b, flush,
                  output ready, busy, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Multiplies take MUL_LAT cycles. Divides are restoring radix-2 and take 32 cycles.
module mdu_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  mdu_ctrl_if.slave  bus
);
  localparam int DATA_W = 32;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [1:0] {K_NONE, K_MUL, K_DIV} kind_t;

  state_t              r_state;
  kind_t               r_kind;
  logic [5:0]          r_cnt;
  logic                r_busy;
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic [DATA_W-1:0]   r_a, r_b, r_rem;
  logic                r_sgn, r_neg_q, r_neg_r;

  logic                w_req, w_is_mul, w_is_div, w_signed, w_div0, w_launch;
  logic signed [63:0]  w_ma, w_mb, w_prod;
  logic [DATA_W:0]     w_shift, w_diff;
  logic                w_sub_ok;

  function automatic logic [DATA_W-1:0] f_abs(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? DATA_W'(-v) : v;
  endfunction

  function automatic logic [DATA_W-1:0] f_fix(input logic [DATA_W-1:0] mag, input logic neg);
    return neg ? DATA_W'(-mag) : mag;
  endfunction

  assign w_req    = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign w_signed = !bus.op[0];
  assign w_div0   = (bus.src_b == '0);
  assign w_launch = w_req && (w_is_mul || w_is_div);

  assign w_ma   = {{32{r_sgn & r_a[DATA_W-1]}}, r_a};
  assign w_mb   = {{32{r_sgn & r_b[DATA_W-1]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // One restoring step: shift in the next dividend bit, try to subtract the divisor.
  assign w_shift  = {r_rem, r_a[DATA_W-1]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_sub_ok = !w_diff[DATA_W];

  assign bus.ready = !((r_state == S_MUL) || (r_state == S_DIV)) && !w_launch;
  assign bus.busy  = r_busy;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_kind  <= K_NONE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_is_mul) begin
              r_state <= S_MUL;
              r_kind  <= K_MUL;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end else if (w_is_div && w_div0) begin
              r_state <= S_DONE;
              r_kind  <= K_NONE;
            end else if (w_is_div) begin
              r_state <= S_DIV;
              r_kind  <= K_DIV;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end else if (bus.op == OP_MTHI) begin
              r_hi <= bus.src_a;
            end else if (bus.op == OP_MTLO) begin
              r_lo <= bus.src_a;
            end
          end
        end
        S_MUL: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == MUL_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_DIV: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == DIV_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_DONE: begin
          if (!bus.flush && r_kind == K_MUL) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end else if (!bus.flush && r_kind == K_DIV) begin
            r_hi <= f_fix(r_rem, r_neg_r);
            r_lo <= f_fix(r_a, r_neg_q);
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Operand and iteration datapath. r_a holds the dividend and collects the quotient bits.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_sgn   <= w_signed;
      r_rem   <= '0;
      r_neg_q <= w_is_div && w_signed && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
      r_neg_r <= w_is_div && w_signed && bus.src_a[DATA_W-1];
      if (w_is_div && w_signed) begin
        r_a <= f_abs(bus.src_a);
        r_b <= f_abs(bus.src_b);
      end else begin
        r_a <= bus.src_a;
        r_b <= bus.src_b;
      end
    end else if (r_state == S_DIV) begin
      r_rem <= w_sub_ok ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
      r_a   <= {r_a[DATA_W-2:0], w_sub_ok};
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl. It drives operations, keeps expected HI/LO in a queue,
// and compares the stall length and the results after each operation finishes.
module tb_mdu_ctrl;
  localparam int MUL_LAT = 4;

  logic clk = 1'b0;
  logic resetn;
  mdu_ctrl_if bus ();

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input logic [31:0] hi, lo);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin sq = sa * sb; return sq; end
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {hi, lo};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        if (b == 0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, input string tag);
    logic [63:0] e;
    int low, exp_low;
    e = model(op, a, b, m_hi, m_lo);
    exp_q.push_back(e);
    m_hi = e[63:32];
    m_lo = e[31:0];
    if (op <= 3'd1)      exp_low = MUL_LAT + 1;
    else if (op <= 3'd3) exp_low = (b == 0) ? 1 : 33;
    else                 exp_low = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    #1;
    low = 0;
    while (!bus.ready && low < 100) begin
      low++;
      @(negedge clk);
      #1;
      if (low == 1) check_val({tag, "_busy"}, 64'(bus.busy), 64'(exp_low > 1));
    end
    check_val({tag, "_stall"}, 64'(low), 64'(exp_low));
    check_val({tag, "_done_busy"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e = exp_q.pop_front();
    check_val({tag, "_hi"}, 64'(bus.hi), 64'(e[63:32]));
    check_val({tag, "_lo"}, 64'(bus.lo), 64'(e[31:0]));
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    logic [63:0] e;
    resetn = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_hi", 64'(bus.hi), 64'd0);
    check_val("rst_lo", 64'(bus.lo), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_ready", 64'(bus.ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    // MTHI then MTLO in back-to-back cycles with ready held high
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'hDEADBEEF;
    #1 check_val("mthi_ready", 64'(bus.ready), 64'd1);
    @(negedge clk);
    bus.op = 3'd5; bus.src_a = 32'h1234;
    #1 check_val("mtlo_ready", 64'(bus.ready), 64'd1);
    m_hi = 32'hDEADBEEF; m_lo = 32'h1234;
    exp_q.push_back({m_hi, m_lo});
    @(posedge clk);
    #1 bus.start = 1'b0;
    e = exp_q.pop_front();
    check_val("mt_hi", 64'(bus.hi), 64'(e[63:32]));
    check_val("mt_lo", 64'(bus.lo), 64'(e[31:0]));

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, "mult_neg");
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg7");
    run_op(3'd3, 32'd7, 32'd2, "divu_7_2");
    run_op(3'd4, 32'h11, 32'd0, "mthi_11");
    run_op(3'd5, 32'h22, 32'd0, "mtlo_22");
    run_op(3'd3, 32'd99, 32'd0, "divu_zero");
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(3'd6, 32'h5555, 32'h7, "noop");
    run_op(3'd2, 32'd7, 32'hFFFFFFFE, "div_pos_neg");

    // Flush a divide in flight
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.src_a = 32'd1000; bus.src_b = 32'd7;
    #1 check_val("flush_req_ready", 64'(bus.ready), 64'd0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    #1 check_val("flush_div_busy", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check_val("flush_ready", 64'(bus.ready), 64'd1);
    check_val("flush_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    check_val("flush_hi", 64'(bus.hi), 64'(m_hi));
    check_val("flush_lo", 64'(bus.lo), 64'(m_lo));
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");

    // Flush in IDLE blocks MTHI
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'hCAFE0000; bus.flush = 1'b1;
    #1 check_val("idle_flush_ready", 64'(bus.ready), 64'd1);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0;
    check_val("idle_flush_hi", 64'(bus.hi), 64'(m_hi));

    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      run_op(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
    end

    // Reset in the middle of a multiply
    run_op(3'd4, 32'h0BADF00D, 32'd0, "pre_rst");
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd5; bus.src_b = 32'd6;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check_val("midrst_busy", 64'(bus.busy), 64'd0);
    check_val("midrst_hi", 64'(bus.hi), 64'd0);
    check_val("midrst_lo", 64'(bus.lo), 64'd0);
    check_val("midrst_ready", 64'(bus.ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (10) @(negedge clk);
    check_val("postrst_hi", 64'(bus.hi), 64'd0);
    check_val("postrst_lo", 64'(bus.lo), 64'd0);
    run_op(3'd0, 32'h7FFFFFFF, 32'h80000000, "mult_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter: MUL_LAT, 4, number of cycles spent in MUL state (legal 1..15).
REQ-002 The block SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: start  input  1  level request from EX stage, held until ready=1.
REQ-005 The block SHALL have port: op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 The block SHALL have port: src_a  input  32  rs operand (multiplicand/dividend/MTHI-MTLO data).
REQ-007 The block SHALL have port: src_b  input  32  rt operand (multiplier/divisor).
REQ-008 The block SHALL have port: flush  input  1  cancel the in-flight operation.
REQ-009 The block SHALL have port: ready  output  1  MDUReadyE to the hazard unit; 0 stalls F/D/E.
REQ-010 The block SHALL have port: busy  output  1  high in MUL or DIV state.
REQ-011 The block SHALL have port: hi  output  32  architectural HI register.
REQ-012 The block SHALL have port: lo  output  32  architectural LO register.

Function
REQ-013 FSM SHALL have states IDLE, MUL, DIV, DONE; busy=1 exactly in MUL and DIV.
REQ-014 IDLE, start=1, flush=0, op=MULT/MULTU: latch operands, clear counter, go to MUL; ready=0 combinationally in this same cycle.
REQ-015 IDLE, start=1, flush=0, op=DIV/DIVU, src_b!=0: latch |operands| (signed) or raw (unsigned) and sign flags, go to DIV; ready=0 same cycle.
REQ-016 IDLE, start=1, flush=0, op=DIV/DIVU, src_b==0: go directly to DONE with no HI/LO write; ready=0 that cycle.
REQ-017 IDLE, start=1, flush=0, op=MTHI/MTLO: write src_a to hi/lo at that clock edge, stay IDLE, ready=1.
REQ-018 op 110/111, or start=0, in IDLE SHALL change nothing; ready=1.
REQ-019 MUL SHALL last exactly MUL_LAT cycles, then DONE; product = 64-bit signed (MULT) or unsigned (MULTU) product of latched operands.
REQ-020 DIV SHALL perform restoring radix-2 division, one quotient bit per cycle, exactly 32 cycles, then DONE.
REQ-021 Signed fixup: quotient negated if dividend and divisor signs differ; remainder takes dividend sign; 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0.
REQ-022 DONE SHALL drive ready=1, ignore start, write hi/lo (mul: hi=product[63:32], lo=product[31:0]; div: hi=remainder, lo=quotient) at the clock edge, return to IDLE.
REQ-023 Total latency SHALL be: request cycle T, DONE at T+MUL_LAT+1 (mul) or T+33 (div) or T+1 (divide-by-zero); new hi/lo visible from the cycle after DONE.
REQ-024 ready SHALL be 0 in MUL and DIV, and 1 in DONE and otherwise in IDLE except REQ-014..016.
REQ-025 flush=1 in MUL, DIV or DONE SHALL return to IDLE next edge with no hi/lo write; flush=1 in IDLE SHALL block start and any MTHI/MTLO write.
REQ-026 Intermediate registers (counter, partial remainder, quotient, latched operands) SHALL not affect hi/lo until DONE.

Reset
REQ-027 resetn=0 SHALL asynchronously force state=IDLE, hi=0, lo=0, counter=0, busy=0; ready=1 while start=0.
REQ-028 Reset mid-operation SHALL discard the operation; first edge after release begins in IDLE.

Verification
REQ-029 MULT src_a=0xFFFFFFFE, src_b=3, MUL_LAT=4 -> ready low 5 cycles, DONE at T+5, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-030 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> ready low 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFD; DIVU 7/2 -> hi=1, lo=3.
REQ-031 DIVU src_b=0 with hi=0x11, lo=0x22 -> ready low 1 cycle, hi/lo unchanged.
REQ-032 MTHI src_a=0xDEADBEEF then MTLO src_a=0x1234 in consecutive cycles -> ready stays 1, hi=0xDEADBEEF, lo=0x1234.
REQ-033 DIV started, flush=1 at cycle 10 -> IDLE next cycle, ready=1, hi/lo unchanged; new MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1.
REQ-034 resetn=0 asserted mid-MUL -> immediately IDLE, hi=lo=0, busy=0; no write at what would have been DONE.
